// File: rtl/calc_sequencer_pkg.sv
// Shared state and error-code encodings for the calculator operation sequencer.
// The numeric values are decoded directly by the input, arithmetic and display units.
package calc_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXECA   = 3'd1,
        ST_CALC    = 3'd2,
        ST_DISPLAY = 3'd3,
        ST_FAULT   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_INPUT   = 2'b01,
        ERR_CALC    = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_e;

    function automatic logic is_busy(input state_e s);
        return s inside {ST_EXECA, ST_CALC, ST_DISPLAY};
    endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Handshake and status bundle between the sequencer (slave) and the units/run switch (master).
// Unit done/error levels and run flow in; state bus, start pulses and status flow out.
interface calc_sequencer_if #(
    parameter int CNT_W = 8
);
    import calc_sequencer_pkg::*;

    logic             run;
    logic             inputed;
    logic             input_error;
    logic             calc_done;
    logic             calc_error;
    logic             disp_done;
    state_e           state;
    logic             calc_start;
    logic             disp_start;
    logic             busy;
    logic             fault;
    err_e             err_code;
    logic [CNT_W-1:0] op_count;

    modport master (
        output run, inputed, input_error, calc_done, calc_error, disp_done,
        input  state, calc_start, disp_start, busy, fault, err_code, op_count
    );

    modport slave (
        input  run, inputed, input_error, calc_done, calc_error, disp_done,
        output state, calc_start, disp_start, busy, fault, err_code, op_count
    );
endinterface

// File: rtl/calc_sequencer_watchdog.sv
// CALC-phase cycle counter, built only when CALC_TIMEOUT_EN is defined; clear dominates enable.
// expired_o is combinational from the count and asserts in the LIMIT-th enabled cycle.
`ifdef CALC_TIMEOUT_EN
module calc_sequencer_watchdog #(
    parameter logic [31:0] LIMIT = 32'd1_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    logic [31:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        cnt_q <= '0;
        else if (clear_i) cnt_q <= '0;
        else if (en_i)    cnt_q <= cnt_q + 32'd1;
    end

    assign expired_o = en_i && (cnt_q == LIMIT - 32'd1);
endmodule
`endif

// File: rtl/calc_sequencer.sv
// Operation sequencer input->calc->display with abort, fault latch and op counter; CALC_TIMEOUT_EN adds a CALC watchdog.
// Every transition lands one cycle after its input is sampled; all outputs come straight from flops.
module calc_sequencer
    import calc_sequencer_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,
    parameter int          CNT_W          = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    calc_sequencer_if.slave bus
);
    state_e           state_q, state_d;
    err_e             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q;
    logic             calc_start_q, disp_start_q, busy_q, fault_q;
    logic             run_rise;
    logic             timeout;

    assign run_rise = bus.run & ~run_q;

`ifdef CALC_TIMEOUT_EN
    calc_sequencer_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (state_q != ST_CALC),
        .en_i      (state_q == ST_CALC),
        .expired_o (timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    // Branch order encodes the priority abort > error > done > timeout.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (run_rise) state_d = ST_EXECA;
            end
            ST_EXECA: begin
                if (!bus.run) begin
                    state_d = ST_IDLE;
                end else if (bus.inputed) begin
                    if (bus.input_error) begin
                        state_d = ST_FAULT;
                        err_d   = ERR_INPUT;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (!bus.run) begin
                    state_d = ST_IDLE;
                end else if (bus.calc_done) begin
                    if (bus.calc_error) begin
                        state_d = ST_FAULT;
                        err_d   = ERR_CALC;
                    end else begin
                        state_d = ST_DISPLAY;
                    end
                end else if (timeout) begin
                    state_d = ST_FAULT;
                    err_d   = ERR_TIMEOUT;
                end
            end
            ST_DISPLAY: begin
                if (!bus.run) begin
                    state_d = ST_IDLE;
                end else if (bus.disp_done) begin
                    state_d = ST_IDLE;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_FAULT: begin
                if (!bus.run) begin
                    state_d = ST_IDLE;
                    err_d   = ERR_NONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            err_q        <= ERR_NONE;
            cnt_q        <= '0;
            run_q        <= 1'b0;
            calc_start_q <= 1'b0;
            disp_start_q <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            run_q        <= bus.run;
            calc_start_q <= (state_d == ST_CALC)    && (state_q != ST_CALC);
            disp_start_q <= (state_d == ST_DISPLAY) && (state_q != ST_DISPLAY);
            busy_q       <= is_busy(state_d);
            fault_q      <= (state_d == ST_FAULT);
        end
    end

    assign bus.state      = state_q;
    assign bus.err_code   = err_q;
    assign bus.op_count   = cnt_q;
    assign bus.calc_start = calc_start_q;
    assign bus.disp_start = disp_start_q;
    assign bus.busy       = busy_q;
    assign bus.fault      = fault_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// Directed plus randomized checks of calc_sequencer against a transaction-level expectation model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_calc_sequencer;
    import calc_sequencer_pkg::*;

    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   exp_count = 0;

    calc_sequencer_if #(.CNT_W(CNT_W)) bus();

    calc_sequencer #(.TIMEOUT_CYCLES(32'd16), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: simulation did not finish within its time budget");
        $fatal(1, "time budget exhausted");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_state"}, bus.state, 0);
        chk({tag, "_err"},   bus.err_code, 0);
        chk({tag, "_busy"},  bus.busy, 0);
        chk({tag, "_fault"}, bus.fault, 0);
        chk({tag, "_cnt"},   bus.op_count, exp_count);
    endtask

    // One operation: a cycles of input wait, b of calc wait, c of display wait.
    task automatic do_op(input int a, input int b, input int c, input bit ierr, input bit cerr);
        bus.run = 1'b1;
        step();
        chk("execa_state", bus.state, 1);
        chk("execa_busy", bus.busy, 1);
        for (int i = 0; i < a; i++) begin
            step();
            chk("execa_wait", bus.state, 1);
        end
        bus.inputed = 1'b1; bus.input_error = ierr;
        step();
        bus.inputed = 1'b0; bus.input_error = 1'b0;
        if (ierr) begin
            chk("ierr_state", bus.state, 4);
            chk("ierr_code", bus.err_code, 1);
            chk("ierr_fault", bus.fault, 1);
            chk("ierr_busy", bus.busy, 0);
            step();
            chk("ierr_hold", bus.err_code, 1);
            bus.run = 1'b0;
            step();
            chk_idle("ierr_exit");
            return;
        end
        for (int i = 0; i <= b; i++) begin
            chk("calc_state", bus.state, 2);
            chk("calc_start", bus.calc_start, (i == 0));
            chk("calc_no_disp", bus.disp_start, 0);
            if (i < b) step();
        end
        bus.calc_done = 1'b1; bus.calc_error = cerr;
        step();
        bus.calc_done = 1'b0; bus.calc_error = 1'b0;
        if (cerr) begin
            chk("cerr_state", bus.state, 4);
            chk("cerr_code", bus.err_code, 2);
            chk("cerr_fault", bus.fault, 1);
            chk("cerr_cnt", bus.op_count, exp_count);
            bus.run = 1'b0;
            step();
            chk_idle("cerr_exit");
            return;
        end
        for (int i = 0; i <= c; i++) begin
            chk("disp_state", bus.state, 3);
            chk("disp_start", bus.disp_start, (i == 0));
            if (i < c) step();
        end
        bus.disp_done = 1'b1;
        step();
        bus.disp_done = 1'b0;
        exp_count = (exp_count + 1) % (1 << CNT_W);
        chk_idle("done");
        step();
        chk("no_restart_while_high", bus.state, 0);
        bus.run = 1'b0;
        step();
    endtask

    initial begin
        int a, b, c;
        bit ie, ce;
        bus.run = 1'b0; bus.inputed = 1'b0; bus.input_error = 1'b0;
        bus.calc_done = 1'b0; bus.calc_error = 1'b0; bus.disp_done = 1'b0;

        step(); step();
        chk_idle("reset");
        chk("reset_cstart", bus.calc_start, 0);
        chk("reset_dstart", bus.disp_start, 0);
        rst = 1'b0;
        step();

        do_op(5, 3, 10, 1'b0, 1'b0);
        chk("full_pass_cnt", bus.op_count, 1);
        do_op(2, 2, 0, 1'b0, 1'b1);
        do_op(1, 0, 0, 1'b1, 1'b0);

        // Abort in CALC with calc_done in the same cycle.
        bus.run = 1'b1; step();
        bus.inputed = 1'b1; step();
        bus.inputed = 1'b0;
        chk("abort_in_calc", bus.state, 2);
        step();
        bus.run = 1'b0; bus.calc_done = 1'b1;
        step();
        bus.calc_done = 1'b0;
        chk_idle("abort");
        chk("abort_no_disp", bus.disp_start, 0);
        step();
        chk("abort_no_disp2", bus.disp_start, 0);

        for (int n = 0; n < 40; n++) begin
            a  = $urandom_range(0, 3);
            b  = $urandom_range(0, 12);
            c  = $urandom_range(0, 3);
            ie = ($urandom_range(0, 7) == 0);
            ce = ($urandom_range(0, 7) == 0);
            do_op(a, b, c, ie, ce);
        end

        bus.run = 1'b1; step();
        bus.inputed = 1'b1; step();
        bus.inputed = 1'b0;
`ifdef CALC_TIMEOUT_EN
        for (int k = 0; k < 16; k++) begin
            chk("to_calc", bus.state, 2);
            step();
        end
        chk("to_state", bus.state, 4);
        chk("to_code", bus.err_code, 3);
        chk("to_fault", bus.fault, 1);
        bus.run = 1'b0; step();
        chk_idle("to_exit");
        bus.run = 1'b1; step();
        bus.inputed = 1'b1; step();
        bus.inputed = 1'b0;
        for (int k = 0; k < 15; k++) step();
        bus.calc_done = 1'b1; step();
        bus.calc_done = 1'b0;
        chk("to_done_wins", bus.state, 3);
        chk("to_done_err", bus.err_code, 0);
`else
        for (int k = 0; k < 40; k++) begin
            chk("no_to_calc", bus.state, 2);
            chk("no_to_err", bus.err_code, 0);
            step();
        end
`endif
        bus.run = 1'b0; step();
        chk_idle("to_abort");

        // Asynchronous reset during the first DISPLAY cycle.
        bus.run = 1'b1; step();
        bus.inputed = 1'b1; step();
        bus.inputed = 1'b0; bus.calc_done = 1'b1; step();
        bus.calc_done = 1'b0;
        chk("rst_pre_disp", bus.state, 3);
        chk("rst_pre_cnt_nonzero", (bus.op_count != 0), 1);
        #2 rst = 1'b1;
        #1;
        exp_count = 0;
        chk_idle("async_rst");
        chk("async_rst_dstart", bus.disp_start, 0);
        chk("async_rst_cstart", bus.calc_start, 0);
        bus.run = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk_idle("post_rst");

        for (int n = 0; n < 256; n++) begin
            do_op($urandom_range(0, 2), $urandom_range(0, 4), $urandom_range(0, 2), 1'b0, 1'b0);
            if (n == 254) chk("wrap_max", bus.op_count, 255);
        end
        chk("wrap_zero", bus.op_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
